// File: rtl/ocspm_arb_if.sv
// ocspm_arb_if: bus bundle between the scratch-pad arbiter and its two
// masters (a classic Wishbone master and an optional DMA engine).
//
// Signals
//   WB_ADRi/WB_DATi/WB_SELi/WB_WEi  Wishbone word address, write data, byte lanes, write enable
//   WB_CYCi/WB_STBi                 Wishbone cycle / strobe
//   WB_DATo/WB_ACKo                 Wishbone read data / acknowledge
//   dma_req/dmaaddr/dma_we/dma_sel/dat_i  DMA request, address, write enable, byte lanes, write data
//   dat_o/dma_gnt/dma_ack           DMA read data, combinational grant, acknowledge
//
// Handshake rules:
//   Wishbone is a classic cycle. The master raises CYC and STB and holds
//   them, with address, data and lanes stable, until it samples ACK high.
//   It may drop CYC at any time to abandon the access, which suppresses
//   its ACK. DMA is valid/grant. The master holds dma_req and its command
//   stable until it sees dma_gnt high in the same cycle; that cycle is the
//   issue cycle. The matching ack (and read data) follows a fixed latency
//   later, and several DMA accesses may be in flight at once.
interface ocspm_arb_if #(
  parameter int DW   = 8,
  parameter int AWID = 10
);
  logic [AWID-1:0] WB_ADRi;
  logic [DW-1:0]   WB_DATi;
  logic [DW-1:0]   WB_DATo;
  logic [DW/8-1:0] WB_SELi;
  logic            WB_WEi;
  logic            WB_CYCi;
  logic            WB_STBi;
  logic            WB_ACKo;

  logic            dma_req;
  logic [AWID-1:0] dmaaddr;
  logic            dma_we;
  logic [DW/8-1:0] dma_sel;
  logic [DW-1:0]   dat_i;
  logic [DW-1:0]   dat_o;
  logic            dma_gnt;
  logic            dma_ack;

  modport slave (
    input  WB_ADRi, WB_DATi, WB_SELi, WB_WEi, WB_CYCi, WB_STBi,
    input  dma_req, dmaaddr, dma_we, dma_sel, dat_i,
    output WB_DATo, WB_ACKo, dat_o, dma_gnt, dma_ack
  );

  modport master (
    output WB_ADRi, WB_DATi, WB_SELi, WB_WEi, WB_CYCi, WB_STBi,
    output dma_req, dmaaddr, dma_we, dma_sel, dat_i,
    input  WB_DATo, WB_ACKo, dat_o, dma_gnt, dma_ack
  );
endinterface

// File: rtl/ocspm_arb.sv
// ocspm_arb: single-ported on-chip scratch-pad memory shared by a Wishbone
// slave port and an optional pipelined DMA port.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   bus        ocspm_arb_if slave modport (Wishbone + DMA signals)
//   dbg_state  owner of the most recently issued access (0 idle, 1 WB, 2 DMA)
//
// One access issues per cycle. DMA normally wins. After DMA_BURST_MAX DMA
// grants while Wishbone waits, Wishbone gets one slot. Every access travels
// down an RD_LAT-deep tag pipeline, and its ack comes out of the last stage.
module ocspm_arb #(
  parameter int DW            = 8,
  parameter int SPM_DEPTH     = 1024,
  parameter int SPM_AWID      = $clog2(SPM_DEPTH),
  parameter bit DMA_PRESENT   = 1'b0,
  parameter int RD_LAT        = 1,
  parameter int DMA_BURST_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  ocspm_arb_if.slave        bus,
  output logic [1:0]        dbg_state
);

  localparam int NB  = DW / 8;
  localparam int SW  = $clog2(DMA_BURST_MAX + 1);
  localparam int LST = RD_LAT - 1;
  localparam logic [SW-1:0]       STARVE_MAX = SW'(DMA_BURST_MAX);
  localparam logic [SPM_AWID:0]   DEPTH_V    = (SPM_AWID + 1)'(SPM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_DMA  = 2'd2
  } state_t;

  logic [DW-1:0] mem [SPM_DEPTH];
  logic [DW-1:0] mem_rd_q;
  logic [DW-1:0] fin_dat;

  state_t        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;

  // Tag pipeline, index 0 = access issued last cycle, LST = completing now.
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] own_dma_q, own_dma_d;
  logic [RD_LAT-1:0] rd_q, rd_d;
  logic [RD_LAT-1:0] live_q, live_d;   // cleared once a WB access is abandoned

  logic [DW-1:0] wb_hold_q, wb_hold_d;
  logic [DW-1:0] dma_hold_q, dma_hold_d;

  logic                wb_req, wb_busy, wb_pend, dma_want;
  logic                grant_wb, grant_dma, acc_en, acc_we, in_range;
  logic [SPM_AWID-1:0] acc_adr;
  logic [NB-1:0]       acc_sel;
  logic [DW-1:0]       acc_wdat;
  logic                fin_wb_ack, fin_wb_rd, fin_dma, fin_dma_rd;

  always_comb begin
    wb_req    = bus.WB_CYCi & bus.WB_STBi;
    wb_busy   = |(vld_q & ~own_dma_q);
    wb_pend   = wb_req & ~wb_busy;
    dma_want  = DMA_PRESENT & bus.dma_req;

    grant_wb  = 1'b0;
    grant_dma = 1'b0;
    if (!rst) begin
      if (dma_want && !(wb_pend && starve_q == STARVE_MAX)) grant_dma = 1'b1;
      else if (wb_pend)                                     grant_wb  = 1'b1;
    end
    acc_en   = grant_wb | grant_dma;

    acc_adr  = grant_dma ? bus.dmaaddr : bus.WB_ADRi;
    acc_we   = grant_dma ? bus.dma_we  : bus.WB_WEi;
    acc_sel  = grant_dma ? bus.dma_sel : bus.WB_SELi;
    acc_wdat = grant_dma ? bus.dat_i   : bus.WB_DATi;
    in_range = ({1'b0, acc_adr} < DEPTH_V);

    // Starvation count only grows while Wishbone is actually waiting.
    starve_d = starve_q;
    if (!wb_pend || grant_wb)                       starve_d = '0;
    else if (grant_dma && starve_q != STARVE_MAX)   starve_d = starve_q + 1'b1;

    if (grant_dma)     state_d = ST_DMA;
    else if (grant_wb) state_d = ST_WB;
    else               state_d = ST_IDLE;

    vld_d     = '0;
    own_dma_d = '0;
    rd_d      = '0;
    live_d    = '0;
    vld_d[0]     = acc_en;
    own_dma_d[0] = grant_dma;
    rd_d[0]      = ~acc_we;
    live_d[0]    = 1'b1;
    for (int k = 1; k < RD_LAT; k++) begin
      vld_d[k]     = vld_q[k-1];
      own_dma_d[k] = own_dma_q[k-1];
      rd_d[k]      = rd_q[k-1];
      live_d[k]    = live_q[k-1] & (own_dma_q[k-1] | bus.WB_CYCi);
    end

    // A WB ack is also dropped if CYC is low in the ack cycle itself.
    fin_wb_ack = vld_q[LST] & ~own_dma_q[LST] & live_q[LST] & bus.WB_CYCi;
    fin_wb_rd  = fin_wb_ack & rd_q[LST];
    fin_dma    = vld_q[LST] & own_dma_q[LST];
    fin_dma_rd = fin_dma & rd_q[LST];

    wb_hold_d  = fin_wb_rd  ? fin_dat : wb_hold_q;
    dma_hold_d = fin_dma_rd ? fin_dat : dma_hold_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      vld_q      <= '0;
      own_dma_q  <= '0;
      rd_q       <= '0;
      live_q     <= '0;
      wb_hold_q  <= '0;
      dma_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      vld_q      <= vld_d;
      own_dma_q  <= own_dma_d;
      rd_q       <= rd_d;
      live_q     <= live_d;
      wb_hold_q  <= wb_hold_d;
      dma_hold_q <= dma_hold_d;
    end
  end

  // Storage is never reset. Writes are per byte lane, and out-of-range
  // addresses neither write nor return data.
  always_ff @(posedge clk) begin
    if (acc_en && acc_we && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (acc_sel[b]) mem[acc_adr][b*8 +: 8] <= acc_wdat[b*8 +: 8];
      end
    end
    if (acc_en && !acc_we) mem_rd_q <= in_range ? mem[acc_adr] : '0;
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [DW-1:0] dat2_q;
    always_ff @(posedge clk) dat2_q <= mem_rd_q;
    assign fin_dat = dat2_q;
  end else begin : g_lat1
    assign fin_dat = mem_rd_q;
  end

  assign bus.WB_ACKo = fin_wb_ack;
  assign bus.WB_DATo = fin_wb_rd ? fin_dat : wb_hold_q;
  assign bus.dma_gnt = grant_dma;
  assign bus.dma_ack = fin_dma;
  assign bus.dat_o   = fin_dma_rd ? fin_dat : dma_hold_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_ocspm_arb.sv
module tb_ocspm_arb;

  logic clk;
  logic rst;
  logic [1:0] dbg_a, dbg_b, dbg_c;
  int n_chk;
  int n_pass;

  // a: DW32, non-power-of-2 depth, RD_LAT 1, DMA with burst limit 4
  // b: DW32, RD_LAT 2, DMA
  // c: DW8, no DMA
  ocspm_arb_if #(.DW(32), .AWID(10)) bus_a ();
  ocspm_arb_if #(.DW(32), .AWID(4))  bus_b ();
  ocspm_arb_if #(.DW(8),  .AWID(4))  bus_c ();

  ocspm_arb #(.DW(32), .SPM_DEPTH(1000), .DMA_PRESENT(1'b1), .RD_LAT(1), .DMA_BURST_MAX(4))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a), .dbg_state(dbg_a));
  ocspm_arb #(.DW(32), .SPM_DEPTH(16), .DMA_PRESENT(1'b1), .RD_LAT(2), .DMA_BURST_MAX(4))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b), .dbg_state(dbg_b));
  ocspm_arb #(.DW(8), .SPM_DEPTH(16), .DMA_PRESENT(1'b0), .RD_LAT(1))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c), .dbg_state(dbg_c));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic set_wb(input int w, input bit cyc, input bit stb, input bit we,
                        input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    case (w)
      0: begin
        bus_a.WB_CYCi = cyc; bus_a.WB_STBi = stb; bus_a.WB_WEi = we;
        bus_a.WB_ADRi = adr[9:0]; bus_a.WB_DATi = dat; bus_a.WB_SELi = sel;
      end
      1: begin
        bus_b.WB_CYCi = cyc; bus_b.WB_STBi = stb; bus_b.WB_WEi = we;
        bus_b.WB_ADRi = adr[3:0]; bus_b.WB_DATi = dat; bus_b.WB_SELi = sel;
      end
      default: begin
        bus_c.WB_CYCi = cyc; bus_c.WB_STBi = stb; bus_c.WB_WEi = we;
        bus_c.WB_ADRi = adr[3:0]; bus_c.WB_DATi = dat[7:0]; bus_c.WB_SELi = sel[0:0];
      end
    endcase
  endtask

  function automatic logic get_ack(input int w);
    case (w)
      0:       return bus_a.WB_ACKo;
      1:       return bus_b.WB_ACKo;
      default: return bus_c.WB_ACKo;
    endcase
  endfunction

  function automatic logic [31:0] get_dat(input int w);
    case (w)
      0:       return bus_a.WB_DATo;
      1:       return bus_b.WB_DATo;
      default: return {24'h0, bus_c.WB_DATo};
    endcase
  endfunction

  // One classic Wishbone access. lat counts cycles from request to ack
  // (0 = ack in request cycle); -1 means no ack within the budget.
  task automatic wb_acc(input int w, input bit we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        output logic [31:0] rd, output int lat);
    lat = -1;
    rd  = '0;
    @(posedge clk); #1;
    set_wb(w, 1'b1, 1'b1, we, adr, dat, sel);
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      if (get_ack(w)) begin
        lat = c;
        rd  = get_dat(w);
        break;
      end
    end
    @(posedge clk); #1;
    set_wb(w, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Single DMA access on b; glat = cycles until grant, -1 if never.
  task automatic dma_b(input bit we, input logic [3:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, output int glat);
    glat = -1;
    @(posedge clk); #1;
    bus_b.dma_req = 1'b1; bus_b.dma_we = we; bus_b.dmaaddr = adr;
    bus_b.dat_i = dat; bus_b.dma_sel = sel;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (bus_b.dma_gnt) begin
        glat = c;
        break;
      end
    end
    @(posedge clk); #1;
    bus_b.dma_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    bus_a.dma_req = 1'b1;
    bus_b.dma_req = 1'b1;
    set_wb(0, 1'b1, 1'b1, 1'b0, 32'd5, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    n_chk++; if (bus_a.WB_ACKo !== 1'b0) $display("FAIL rst_wb_ack got=%b exp=0", bus_a.WB_ACKo); else n_pass++;
    n_chk++; if (bus_a.dma_ack !== 1'b0) $display("FAIL rst_dma_ack got=%b exp=0", bus_a.dma_ack); else n_pass++;
    n_chk++; if (bus_a.WB_DATo !== 32'h0) $display("FAIL rst_wb_dat got=%h exp=0", bus_a.WB_DATo); else n_pass++;
    n_chk++; if (bus_a.dat_o !== 32'h0) $display("FAIL rst_dat_o got=%h exp=0", bus_a.dat_o); else n_pass++;
    n_chk++; if (bus_a.dma_gnt !== 1'b0) $display("FAIL rst_gnt_a got=%b exp=0", bus_a.dma_gnt); else n_pass++;
    n_chk++; if (bus_b.dma_gnt !== 1'b0) $display("FAIL rst_gnt_b got=%b exp=0", bus_b.dma_gnt); else n_pass++;
    n_chk++; if (dbg_a !== 2'd0) $display("FAIL rst_state got=%0d exp=0", dbg_a); else n_pass++;
    bus_a.dma_req = 1'b0;
    bus_b.dma_req = 1'b0;
    set_wb(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_wb_rw;
    logic [31:0] rd;
    int lat;
    wb_acc(0, 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, rd, lat);
    n_chk++; if (lat !== 1) $display("FAIL wr_lat got=%0d exp=1", lat); else n_pass++;
    wb_acc(0, 1'b0, 32'd5, 32'h0, 4'hF, rd, lat);
    n_chk++; if (lat !== 1) $display("FAIL rd_lat got=%0d exp=1", lat); else n_pass++;
    n_chk++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", rd); else n_pass++;
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd;
    int lat;
    wb_acc(0, 1'b1, 32'd5, 32'h00AA0000, 4'b0100, rd, lat);
    wb_acc(0, 1'b0, 32'd5, 32'h0, 4'hF, rd, lat);
    n_chk++; if (rd !== 32'hDEAABEEF) $display("FAIL lane_merge got=%h exp=deaabeef", rd); else n_pass++;
    wb_acc(0, 1'b1, 32'd5, 32'h12345678, 4'b0000, rd, lat);
    n_chk++; if (lat !== 1) $display("FAIL sel0_ack got=%0d exp=1", lat); else n_pass++;
    n_chk++; if (bus_a.WB_DATo !== 32'hDEAABEEF) $display("FAIL dat_hold got=%h exp=deaabeef", bus_a.WB_DATo); else n_pass++;
    wb_acc(0, 1'b0, 32'd5, 32'h0, 4'hF, rd, lat);
    n_chk++; if (rd !== 32'hDEAABEEF) $display("FAIL sel0_nowrite got=%h exp=deaabeef", rd); else n_pass++;
  endtask

  task automatic test_addr_wrap;
    logic [31:0] rd;
    int lat;
    wb_acc(0, 1'b1, 32'd1010, 32'hCAFEF00D, 4'hF, rd, lat);
    n_chk++; if (lat !== 1) $display("FAIL oor_wr_ack got=%0d exp=1", lat); else n_pass++;
    wb_acc(0, 1'b0, 32'd1010, 32'h0, 4'hF, rd, lat);
    n_chk++; if (lat !== 1) $display("FAIL oor_rd_ack got=%0d exp=1", lat); else n_pass++;
    n_chk++; if (rd !== 32'h0) $display("FAIL oor_rd_data got=%h exp=0", rd); else n_pass++;
  endtask

  task automatic test_dma_burst;
    logic [31:0] rd;
    int lat;
    logic [7:0] exp_gnt;
    logic [7:0] exp_wack;
    logic [7:0] exp_dack;
    exp_gnt  = 8'hEF;   // grants c0..c3, Wishbone slot c4, DMA resumes c5..
    exp_wack = 8'h20;   // WB ack at c5
    exp_dack = 8'hDE;   // DMA acks one cycle after each DMA grant
    wb_acc(0, 1'b1, 32'd0, 32'h01020304, 4'hF, rd, lat);
    @(posedge clk); #1;
    bus_a.dma_req = 1'b1; bus_a.dma_we = 1'b0; bus_a.dmaaddr = 10'd5; bus_a.dma_sel = 4'hF;
    set_wb(0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h0, 4'hF);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_chk++; if (bus_a.dma_gnt !== exp_gnt[c]) $display("FAIL burst_gnt c=%0d got=%b exp=%b", c, bus_a.dma_gnt, exp_gnt[c]); else n_pass++;
      n_chk++; if (bus_a.WB_ACKo !== exp_wack[c]) $display("FAIL burst_wback c=%0d got=%b exp=%b", c, bus_a.WB_ACKo, exp_wack[c]); else n_pass++;
      n_chk++; if (bus_a.dma_ack !== exp_dack[c]) $display("FAIL burst_dack c=%0d got=%b exp=%b", c, bus_a.dma_ack, exp_dack[c]); else n_pass++;
      if (c == 1) begin
        n_chk++; if (bus_a.dat_o !== 32'hDEAABEEF) $display("FAIL burst_dat_o got=%h exp=deaabeef", bus_a.dat_o); else n_pass++;
      end
      if (c == 5) begin
        n_chk++; if (bus_a.WB_DATo !== 32'h01020304) $display("FAIL burst_wb_dat got=%h exp=01020304", bus_a.WB_DATo); else n_pass++;
        n_chk++; if (dbg_a !== 2'd1) $display("FAIL burst_state got=%0d exp=1", dbg_a); else n_pass++;
      end
      @(posedge clk); #1;
      if (c == 5) set_wb(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    end
    bus_a.dma_req = 1'b0;
  endtask

  task automatic test_dma_pipe;
    int glat;
    logic [31:0] vals [3];
    logic [5:0] exp_gnt;
    logic [5:0] exp_ack;
    vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
    exp_gnt = 6'b000111;
    exp_ack = 6'b011100;
    for (int i = 0; i < 3; i++) begin
      dma_b(1'b1, 4'(i), vals[i], 4'hF, glat);
      n_chk++; if (glat !== 0) $display("FAIL dma_wr_gnt i=%0d got=%0d exp=0", i, glat); else n_pass++;
    end
    repeat (2) @(posedge clk);
    #1;
    bus_b.dma_req = 1'b1; bus_b.dma_we = 1'b0; bus_b.dmaaddr = 4'd0; bus_b.dma_sel = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_chk++; if (bus_b.dma_gnt !== exp_gnt[c]) $display("FAIL pipe_gnt c=%0d got=%b exp=%b", c, bus_b.dma_gnt, exp_gnt[c]); else n_pass++;
      n_chk++; if (bus_b.dma_ack !== exp_ack[c]) $display("FAIL pipe_ack c=%0d got=%b exp=%b", c, bus_b.dma_ack, exp_ack[c]); else n_pass++;
      if (c >= 2 && c <= 4) begin
        n_chk++; if (bus_b.dat_o !== vals[c-2]) $display("FAIL pipe_dat c=%0d got=%h exp=%h", c, bus_b.dat_o, vals[c-2]); else n_pass++;
      end
      @(posedge clk); #1;
      if (c < 2) bus_b.dmaaddr = 4'(c + 1);
      else       bus_b.dma_req = 1'b0;
    end
  endtask

  task automatic test_wb_abort;
    logic [31:0] rd;
    int lat;
    wb_acc(1, 1'b1, 32'd3, 32'h0BADCAFE, 4'hF, rd, lat);
    n_chk++; if (lat !== 2) $display("FAIL lat2_wr got=%0d exp=2", lat); else n_pass++;
    @(posedge clk); #1;
    set_wb(1, 1'b1, 1'b1, 1'b0, 32'd3, 32'h0, 4'hF);
    @(negedge clk);
    @(posedge clk); #1;
    set_wb(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      n_chk++; if (bus_b.WB_ACKo !== 1'b0) $display("FAIL abort_ack c=%0d got=%b exp=0", c, bus_b.WB_ACKo); else n_pass++;
    end
    wb_acc(1, 1'b0, 32'd3, 32'h0, 4'hF, rd, lat);
    n_chk++; if (lat !== 2) $display("FAIL abort_next_lat got=%0d exp=2", lat); else n_pass++;
    n_chk++; if (rd !== 32'h0BADCAFE) $display("FAIL abort_next_dat got=%h exp=0badcafe", rd); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    int lat;
    @(posedge clk); #1;
    set_wb(0, 1'b1, 1'b1, 1'b1, 32'd9, 32'h13579BDF, 4'hF);
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (bus_a.WB_ACKo !== 1'b0) $display("FAIL mid_rst_ack got=%b exp=0", bus_a.WB_ACKo); else n_pass++;
    n_chk++; if (bus_a.dma_ack !== 1'b0) $display("FAIL mid_rst_dack got=%b exp=0", bus_a.dma_ack); else n_pass++;
    n_chk++; if (bus_a.dat_o !== 32'h0) $display("FAIL mid_rst_dat_o got=%h exp=0", bus_a.dat_o); else n_pass++;
    n_chk++; if (bus_a.WB_DATo !== 32'h0) $display("FAIL mid_rst_wb_dat got=%h exp=0", bus_a.WB_DATo); else n_pass++;
    set_wb(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    wb_acc(0, 1'b0, 32'd9, 32'h0, 4'hF, rd, lat);
    n_chk++; if (rd !== 32'h13579BDF) $display("FAIL mid_rst_word got=%h exp=13579bdf", rd); else n_pass++;
    wb_acc(0, 1'b0, 32'd5, 32'h0, 4'hF, rd, lat);
    n_chk++; if (rd !== 32'hDEAABEEF) $display("FAIL mid_rst_keep got=%h exp=deaabeef", rd); else n_pass++;
  endtask

  task automatic test_no_dma;
    logic [31:0] rd;
    int lat;
    bus_c.dma_req = 1'b1; bus_c.dma_we = 1'b1; bus_c.dmaaddr = 4'd3;
    bus_c.dat_i = 8'hFF; bus_c.dma_sel = 1'b1;
    wb_acc(2, 1'b1, 32'd3, 32'h5A, 4'h1, rd, lat);
    n_chk++; if (lat !== 1) $display("FAIL nodma_wr_lat got=%0d exp=1", lat); else n_pass++;
    @(negedge clk);
    n_chk++; if (bus_c.dma_gnt !== 1'b0) $display("FAIL nodma_gnt got=%b exp=0", bus_c.dma_gnt); else n_pass++;
    n_chk++; if (bus_c.dma_ack !== 1'b0) $display("FAIL nodma_ack got=%b exp=0", bus_c.dma_ack); else n_pass++;
    n_chk++; if (bus_c.dat_o !== 8'h0) $display("FAIL nodma_dat_o got=%h exp=0", bus_c.dat_o); else n_pass++;
    wb_acc(2, 1'b0, 32'd3, 32'h0, 4'h1, rd, lat);
    n_chk++; if (lat !== 1) $display("FAIL nodma_rd_lat got=%0d exp=1", lat); else n_pass++;
    n_chk++; if (rd !== 32'h5A) $display("FAIL nodma_rd got=%h exp=5a", rd); else n_pass++;
    bus_c.dma_req = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b0;
    set_wb(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_wb(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_wb(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    bus_a.dma_req = 1'b0; bus_a.dmaaddr = '0; bus_a.dma_we = 1'b0; bus_a.dma_sel = '0; bus_a.dat_i = '0;
    bus_b.dma_req = 1'b0; bus_b.dmaaddr = '0; bus_b.dma_we = 1'b0; bus_b.dma_sel = '0; bus_b.dat_i = '0;
    bus_c.dma_req = 1'b0; bus_c.dmaaddr = '0; bus_c.dma_we = 1'b0; bus_c.dma_sel = '0; bus_c.dat_i = '0;
    #2 rst = 1'b1;

    test_reset();
    test_wb_rw();
    test_byte_lanes();
    test_addr_wrap();
    test_dma_burst();
    test_dma_pipe();
    test_wb_abort();
    test_reset_mid();
    test_no_dma();

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
